// File: rtl/reorder_buffer_if.sv
// Dispatch, writeback and commit signal bundle for the reorder buffer.
// The master modport is the core side; the slave modport is the buffer itself.
interface reorder_buffer_if #(
  parameter int ROB_IDX_WIDTH = 5
);
  logic                     alloc_valid;
  logic [4:0]               alloc_rd_addr;
  logic                     alloc_regf_we;
  logic                     alloc_ready;
  logic [ROB_IDX_WIDTH-1:0] alloc_rob_idx;

  logic                     wb_valid;
  logic [ROB_IDX_WIDTH-1:0] wb_rob_idx;
  logic [31:0]              wb_data;

  logic                     flush;

  logic                     commit_valid;
  logic [ROB_IDX_WIDTH-1:0] commit_rob_idx;
  logic [4:0]               commit_rd_addr;
  logic [31:0]              commit_data;
  logic                     commit_regf_we;

  logic [ROB_IDX_WIDTH:0]   count;
  logic                     empty;
  logic                     full;

  modport master (
    output alloc_valid, alloc_rd_addr, alloc_regf_we,
    input  alloc_ready, alloc_rob_idx,
    output wb_valid, wb_rob_idx, wb_data,
    output flush,
    input  commit_valid, commit_rob_idx, commit_rd_addr, commit_data, commit_regf_we,
    input  count, empty, full
  );

  modport slave (
    input  alloc_valid, alloc_rd_addr, alloc_regf_we,
    output alloc_ready, alloc_rob_idx,
    input  wb_valid, wb_rob_idx, wb_data,
    input  flush,
    output commit_valid, commit_rob_idx, commit_rd_addr, commit_data, commit_regf_we,
    output count, empty, full
  );
endinterface

// File: rtl/reorder_buffer.sv
// Circular reorder buffer: in-order allocation, out-of-order writeback by index,
// and strictly in-order retirement of one completed entry per cycle.
module reorder_buffer #(
  parameter int ROB_DEPTH     = 32,
  parameter int ROB_IDX_WIDTH = 5
) (
  input logic             clk,
  input logic             rst,
  reorder_buffer_if.slave bus
);
  typedef logic [ROB_IDX_WIDTH-1:0] idx_t;
  typedef logic [ROB_IDX_WIDTH:0]   cnt_t;

  logic [ROB_DEPTH-1:0] ent_valid;
  logic [ROB_DEPTH-1:0] ent_done;
  logic [ROB_DEPTH-1:0] ent_regf_we;
  logic [4:0]           ent_rd   [ROB_DEPTH];
  logic [31:0]          ent_data [ROB_DEPTH];

  idx_t head;
  idx_t tail;
  cnt_t count_q;
  cnt_t count_next;

  logic full_w;
  logic alloc_fire;
  logic wb_fire;
  logic commit_fire;

  assign full_w      = (count_q == cnt_t'(ROB_DEPTH));
  assign alloc_fire  = bus.alloc_valid && !full_w;
  assign wb_fire     = bus.wb_valid && ent_valid[bus.wb_rob_idx];
  assign commit_fire = ent_valid[head] && ent_done[head];

  assign bus.alloc_ready   = !full_w;
  assign bus.alloc_rob_idx = tail;
  assign bus.count         = count_q;
  assign bus.empty         = (count_q == '0);
  assign bus.full          = full_w;

  always_comb begin
    count_next = count_q;
    if (alloc_fire && !commit_fire) begin
      count_next = count_q + cnt_t'(1);
    end else if (!alloc_fire && commit_fire) begin
      count_next = count_q - cnt_t'(1);
    end
  end

  // Payload is only meaningful while the matching valid bit is set, so it needs no reset.
  always_ff @(posedge clk) begin
    if (!bus.flush) begin
      if (alloc_fire) begin
        ent_rd[tail]      <= bus.alloc_rd_addr;
        ent_regf_we[tail] <= bus.alloc_regf_we;
        ent_data[tail]    <= 32'd0;
      end
      if (wb_fire) begin
        ent_data[bus.wb_rob_idx] <= bus.wb_data;
      end
    end
  end

  // Commit clears after writeback so a late rewrite of the retiring head cannot revive it.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ent_valid          <= '0;
      ent_done           <= '0;
      head               <= '0;
      tail               <= '0;
      count_q            <= '0;
      bus.commit_valid   <= 1'b0;
      bus.commit_rob_idx <= '0;
      bus.commit_rd_addr <= 5'd0;
      bus.commit_data    <= 32'd0;
      bus.commit_regf_we <= 1'b0;
    end else if (bus.flush) begin
      ent_valid        <= '0;
      ent_done         <= '0;
      head             <= '0;
      tail             <= '0;
      count_q          <= '0;
      bus.commit_valid <= 1'b0;
    end else begin
      bus.commit_valid <= commit_fire;
      count_q          <= count_next;
      if (alloc_fire) begin
        ent_valid[tail] <= 1'b1;
        ent_done[tail]  <= 1'b0;
        tail            <= tail + idx_t'(1);
      end
      if (wb_fire) begin
        ent_done[bus.wb_rob_idx] <= 1'b1;
      end
      if (commit_fire) begin
        ent_valid[head]    <= 1'b0;
        ent_done[head]     <= 1'b0;
        head               <= head + idx_t'(1);
        bus.commit_rob_idx <= head;
        bus.commit_rd_addr <= ent_rd[head];
        bus.commit_data    <= ent_data[head];
        bus.commit_regf_we <= ent_regf_we[head] && (ent_rd[head] != 5'd0);
      end
    end
  end
endmodule

// File: tb/tb_reorder_buffer.sv
// Scenario and randomized checks of reorder_buffer against a queue-based program-order model.
module tb_reorder_buffer;
  logic clk = 1'b0;
  logic rst = 1'b0;
  int   checks = 0;
  int   failures = 0;

  always #5 clk = ~clk;

  reorder_buffer_if #(.ROB_IDX_WIDTH(5)) bus ();

  reorder_buffer #(.ROB_DEPTH(32), .ROB_IDX_WIDTH(5)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // In-flight instructions in program order; front is the oldest.
  typedef struct {
    logic [4:0]  idx;
    logic [4:0]  rd;
    logic        we;
    logic        done;
    logic [31:0] data;
  } ent_t;

  ent_t        q[$];
  logic [4:0]  m_tail;
  logic        m_cv;
  logic [4:0]  m_cidx;
  logic [4:0]  m_crd;
  logic [31:0] m_cdata;
  logic        m_cwe;

  task automatic model_reset();
    q.delete();
    m_tail = 5'd0;
    m_cv = 1'b0;
    m_cidx = 5'd0;
    m_crd = 5'd0;
    m_cdata = 32'd0;
    m_cwe = 1'b0;
  endtask

  task automatic model_step();
    bit do_commit;
    bit do_alloc;
    if (bus.flush) begin
      q.delete();
      m_tail = 5'd0;
      m_cv = 1'b0;
      return;
    end
    do_commit = (q.size() > 0) && q[0].done;
    do_alloc = bus.alloc_valid && (q.size() < 32);
    m_cv = do_commit;
    if (do_commit) begin
      m_cidx = q[0].idx;
      m_crd = q[0].rd;
      m_cdata = q[0].data;
      m_cwe = q[0].we && (q[0].rd != 5'd0);
    end
    if (bus.wb_valid) begin
      foreach (q[i]) begin
        if (q[i].idx == bus.wb_rob_idx) begin
          q[i].done = 1'b1;
          q[i].data = bus.wb_data;
        end
      end
    end
    if (do_commit) void'(q.pop_front());
    if (do_alloc) begin
      q.push_back('{idx: m_tail, rd: bus.alloc_rd_addr, we: bus.alloc_regf_we, done: 1'b0, data: 32'd0});
      m_tail = m_tail + 5'd1;
    end
  endtask

  task automatic idle();
    bus.alloc_valid = 1'b0;
    bus.alloc_rd_addr = 5'd0;
    bus.alloc_regf_we = 1'b0;
    bus.wb_valid = 1'b0;
    bus.wb_rob_idx = 5'd0;
    bus.wb_data = 32'd0;
    bus.flush = 1'b0;
  endtask

  task automatic drive_alloc(input logic [4:0] rd, input logic we);
    bus.alloc_valid = 1'b1;
    bus.alloc_rd_addr = rd;
    bus.alloc_regf_we = we;
  endtask

  task automatic drive_wb(input logic [4:0] idx, input logic [31:0] data);
    bus.wb_valid = 1'b1;
    bus.wb_rob_idx = idx;
    bus.wb_data = data;
  endtask

  task automatic cycle();
    if (rst) model_step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    idle();
    rst = 1'b0;
    model_reset();
    @(posedge clk);
    #1;
    rst = 1'b1;
  endtask

  task automatic test_reset();
    idle();
    rst = 1'b0;
    model_reset();
    #2;
    checks++;
    if (bus.count !== 6'd0 || bus.empty !== 1'b1 || bus.full !== 1'b0)
      begin failures++; $display("[TB] FAIL reset_occupancy got count=%0d empty=%b full=%b exp 0/1/0", bus.count, bus.empty, bus.full); end
    checks++;
    if (bus.alloc_ready !== 1'b1 || bus.alloc_rob_idx !== 5'd0)
      begin failures++; $display("[TB] FAIL reset_alloc got ready=%b idx=%0d exp 1/0", bus.alloc_ready, bus.alloc_rob_idx); end
    checks++;
    if (bus.commit_valid !== 1'b0 || bus.commit_rob_idx !== 5'd0 || bus.commit_rd_addr !== 5'd0 ||
        bus.commit_data !== 32'd0 || bus.commit_regf_we !== 1'b0)
      begin failures++; $display("[TB] FAIL reset_commit got v=%b idx=%0d rd=%0d data=%h we=%b exp all 0", bus.commit_valid, bus.commit_rob_idx, bus.commit_rd_addr, bus.commit_data, bus.commit_regf_we); end
    @(posedge clk);
    #1;
    rst = 1'b1;
  endtask

  task automatic test_single();
    do_reset();
    drive_alloc(5'd5, 1'b1);
    cycle();
    idle();
    checks++;
    if (bus.count !== 6'd1 || bus.alloc_rob_idx !== 5'd1 || bus.empty !== 1'b0)
      begin failures++; $display("[TB] FAIL single_alloc got count=%0d idx=%0d empty=%b exp 1/1/0", bus.count, bus.alloc_rob_idx, bus.empty); end
    drive_wb(5'd0, 32'hDEADBEEF);
    cycle();
    idle();
    checks++;
    if (bus.commit_valid !== 1'b0)
      begin failures++; $display("[TB] FAIL single_no_bypass got commit_valid=%b exp 0", bus.commit_valid); end
    cycle();
    checks++;
    if (bus.commit_valid !== 1'b1 || bus.commit_rob_idx !== 5'd0 || bus.commit_rd_addr !== 5'd5 ||
        bus.commit_data !== 32'hDEADBEEF || bus.commit_regf_we !== 1'b1)
      begin failures++; $display("[TB] FAIL single_commit got v=%b idx=%0d rd=%0d data=%h we=%b exp 1/0/5/deadbeef/1", bus.commit_valid, bus.commit_rob_idx, bus.commit_rd_addr, bus.commit_data, bus.commit_regf_we); end
    checks++;
    if (bus.count !== 6'd0 || bus.empty !== 1'b1)
      begin failures++; $display("[TB] FAIL single_drain got count=%0d empty=%b exp 0/1", bus.count, bus.empty); end
    cycle();
    checks++;
    if (bus.commit_valid !== 1'b0 || bus.commit_data !== 32'hDEADBEEF)
      begin failures++; $display("[TB] FAIL single_pulse got v=%b data=%h exp 0/deadbeef", bus.commit_valid, bus.commit_data); end
  endtask

  task automatic test_out_of_order();
    do_reset();
    for (int i = 0; i < 3; i++) begin
      drive_alloc(5'(i + 1), 1'b1);
      cycle();
    end
    idle();
    for (int i = 2; i >= 0; i--) begin
      drive_wb(5'(i), 32'h1000 + 32'(i));
      cycle();
      idle();
      checks++;
      if (bus.commit_valid !== 1'b0)
        begin failures++; $display("[TB] FAIL ooo_early_commit wb=%0d got v=%b exp 0", i, bus.commit_valid); end
    end
    for (int k = 0; k < 3; k++) begin
      cycle();
      checks++;
      if (bus.commit_valid !== 1'b1 || bus.commit_rob_idx !== 5'(k) || bus.commit_data !== 32'h1000 + 32'(k) ||
          bus.commit_rd_addr !== 5'(k + 1))
        begin failures++; $display("[TB] FAIL ooo_order k=%0d got v=%b idx=%0d rd=%0d data=%h exp 1/%0d/%0d/%h", k, bus.commit_valid, bus.commit_rob_idx, bus.commit_rd_addr, bus.commit_data, k, k + 1, 32'h1000 + k); end
    end
    cycle();
    checks++;
    if (bus.commit_valid !== 1'b0 || bus.empty !== 1'b1)
      begin failures++; $display("[TB] FAIL ooo_end got v=%b empty=%b exp 0/1", bus.commit_valid, bus.empty); end
  endtask

  task automatic test_full_wrap();
    do_reset();
    for (int i = 0; i < 32; i++) begin
      drive_alloc(5'(i + 1), 1'b1);
      cycle();
    end
    idle();
    checks++;
    if (bus.full !== 1'b1 || bus.alloc_ready !== 1'b0 || bus.count !== 6'd32)
      begin failures++; $display("[TB] FAIL full_state got full=%b ready=%b count=%0d exp 1/0/32", bus.full, bus.alloc_ready, bus.count); end
    drive_alloc(5'd7, 1'b1);
    cycle();
    idle();
    checks++;
    if (bus.count !== 6'd32 || bus.alloc_rob_idx !== 5'd0)
      begin failures++; $display("[TB] FAIL full_drop got count=%0d idx=%0d exp 32/0", bus.count, bus.alloc_rob_idx); end
    drive_wb(5'd0, 32'hA5A50000);
    cycle();
    idle();
    cycle();
    checks++;
    if (bus.commit_valid !== 1'b1 || bus.commit_rob_idx !== 5'd0 || bus.commit_rd_addr !== 5'd1 || bus.commit_data !== 32'hA5A50000)
      begin failures++; $display("[TB] FAIL wrap_commit got v=%b idx=%0d rd=%0d data=%h exp 1/0/1/a5a50000", bus.commit_valid, bus.commit_rob_idx, bus.commit_rd_addr, bus.commit_data); end
    checks++;
    if (bus.count !== 6'd31 || bus.alloc_ready !== 1'b1 || bus.alloc_rob_idx !== 5'd0)
      begin failures++; $display("[TB] FAIL wrap_room got count=%0d ready=%b idx=%0d exp 31/1/0", bus.count, bus.alloc_ready, bus.alloc_rob_idx); end
    drive_alloc(5'd9, 1'b1);
    cycle();
    idle();
    checks++;
    if (bus.count !== 6'd32 || bus.full !== 1'b1 || bus.alloc_rob_idx !== 5'd1)
      begin failures++; $display("[TB] FAIL wrap_refill got count=%0d full=%b idx=%0d exp 32/1/1", bus.count, bus.full, bus.alloc_rob_idx); end
  endtask

  task automatic test_x0();
    do_reset();
    drive_alloc(5'd0, 1'b1);
    cycle();
    idle();
    drive_wb(5'd0, 32'h1234);
    cycle();
    idle();
    cycle();
    checks++;
    if (bus.commit_valid !== 1'b1 || bus.commit_regf_we !== 1'b0 || bus.commit_data !== 32'h1234)
      begin failures++; $display("[TB] FAIL x0_commit got v=%b we=%b data=%h exp 1/0/1234", bus.commit_valid, bus.commit_regf_we, bus.commit_data); end
  endtask

  task automatic test_flush();
    do_reset();
    for (int i = 0; i < 4; i++) begin
      drive_alloc(5'(i + 3), 1'b1);
      cycle();
    end
    idle();
    drive_wb(5'd2, 32'h22);
    cycle();
    drive_wb(5'd3, 32'h33);
    cycle();
    idle();
    checks++;
    if (bus.count !== 6'd4 || bus.commit_valid !== 1'b0)
      begin failures++; $display("[TB] FAIL flush_setup got count=%0d v=%b exp 4/0", bus.count, bus.commit_valid); end
    drive_alloc(5'd3, 1'b1);
    drive_wb(5'd0, 32'h44);
    bus.flush = 1'b1;
    cycle();
    idle();
    checks++;
    if (bus.commit_valid !== 1'b0 || bus.count !== 6'd0 || bus.empty !== 1'b1 || bus.alloc_rob_idx !== 5'd0)
      begin failures++; $display("[TB] FAIL flush_state got v=%b count=%0d empty=%b idx=%0d exp 0/0/1/0", bus.commit_valid, bus.count, bus.empty, bus.alloc_rob_idx); end
    cycle();
    checks++;
    if (bus.commit_valid !== 1'b0 || bus.count !== 6'd0)
      begin failures++; $display("[TB] FAIL flush_after got v=%b count=%0d exp 0/0", bus.commit_valid, bus.count); end
  endtask

  task automatic test_async_reset();
    do_reset();
    for (int i = 0; i < 3; i++) begin
      drive_alloc(5'(i + 10), 1'b1);
      cycle();
    end
    idle();
    drive_wb(5'd0, 32'hCAFE0001);
    cycle();
    drive_wb(5'd2, 32'hCAFE0003);
    cycle();
    idle();
    checks++;
    if (bus.commit_valid !== 1'b1 || bus.commit_data !== 32'hCAFE0001 || bus.count !== 6'd2)
      begin failures++; $display("[TB] FAIL areset_setup got v=%b data=%h count=%0d exp 1/cafe0001/2", bus.commit_valid, bus.commit_data, bus.count); end
    #3;
    rst = 1'b0;
    model_reset();
    #1;
    checks++;
    if (bus.count !== 6'd0 || bus.empty !== 1'b1 || bus.full !== 1'b0 || bus.alloc_ready !== 1'b1 || bus.alloc_rob_idx !== 5'd0)
      begin failures++; $display("[TB] FAIL areset_state got count=%0d empty=%b full=%b ready=%b idx=%0d exp 0/1/0/1/0", bus.count, bus.empty, bus.full, bus.alloc_ready, bus.alloc_rob_idx); end
    checks++;
    if (bus.commit_valid !== 1'b0 || bus.commit_data !== 32'd0 || bus.commit_rob_idx !== 5'd0 ||
        bus.commit_rd_addr !== 5'd0 || bus.commit_regf_we !== 1'b0)
      begin failures++; $display("[TB] FAIL areset_commit got v=%b idx=%0d rd=%0d data=%h we=%b exp all 0", bus.commit_valid, bus.commit_rob_idx, bus.commit_rd_addr, bus.commit_data, bus.commit_regf_we); end
    @(posedge clk);
    #1;
    rst = 1'b1;
    drive_wb(5'd1, 32'hCAFE0002);
    cycle();
    idle();
    for (int i = 0; i < 3; i++) begin
      cycle();
      checks++;
      if (bus.commit_valid !== 1'b0 || bus.count !== 6'd0)
        begin failures++; $display("[TB] FAIL areset_quiet cyc=%0d got v=%b count=%0d exp 0/0", i, bus.commit_valid, bus.count); end
    end
  endtask

  task automatic test_random();
    do_reset();
    for (int n = 0; n < 800; n++) begin
      bus.alloc_valid = ($urandom_range(0, 99) < 70);
      bus.alloc_rd_addr = 5'($urandom);
      bus.alloc_regf_we = 1'($urandom);
      bus.wb_valid = ($urandom_range(0, 99) < 55);
      if (q.size() > 0 && $urandom_range(0, 3) != 0)
        bus.wb_rob_idx = q[$urandom_range(0, q.size() - 1)].idx;
      else
        bus.wb_rob_idx = 5'($urandom);
      bus.wb_data = $urandom;
      bus.flush = ($urandom_range(0, 99) < 2);
      cycle();
      checks++;
      if (bus.count !== 6'(q.size()) || bus.full !== (q.size() == 32) || bus.empty !== (q.size() == 0) ||
          bus.alloc_ready !== (q.size() < 32) || bus.alloc_rob_idx !== m_tail)
        begin failures++; $display("[TB] FAIL rand_occupancy n=%0d got count=%0d idx=%0d exp count=%0d idx=%0d", n, bus.count, bus.alloc_rob_idx, q.size(), m_tail); end
      checks++;
      if (bus.commit_valid !== m_cv || bus.commit_rob_idx !== m_cidx || bus.commit_rd_addr !== m_crd ||
          bus.commit_data !== m_cdata || bus.commit_regf_we !== m_cwe)
        begin failures++; $display("[TB] FAIL rand_commit n=%0d got v=%b idx=%0d rd=%0d data=%h we=%b exp v=%b idx=%0d rd=%0d data=%h we=%b", n, bus.commit_valid, bus.commit_rob_idx, bus.commit_rd_addr, bus.commit_data, bus.commit_regf_we, m_cv, m_cidx, m_crd, m_cdata, m_cwe); end
    end
    idle();
  endtask

  initial begin
    test_reset();
    test_single();
    test_out_of_order();
    test_full_wrap();
    test_x0();
    test_flush();
    test_async_reset();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
